// File: rtl/case_example_pkg.sv
// Shared opcode encoding for the case_example ALU slice.
package case_example_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } opcode_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/case_example_alu.sv
// Combinational four-operation core: result, carry/borrow and zero flag.
module case_example_alu
  import case_example_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] ext;

  always_comb begin
    r     = '0;
    carry = 1'b0;
    ext   = '0;
    case (sel)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        r     = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      // Top bit of the widened difference is set exactly when a < b.
      OP_SUB: begin
        ext   = {1'b0, a} - {1'b0, b};
        r     = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: begin
        r     = '0;
        carry = 1'b0;
      end
    endcase
    zero = (r == '0);
  end

endmodule

// File: rtl/case_example.sv
// Registered ALU: combinational core followed by one output register stage.
module case_example
  import case_example_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] core_r;
  logic             core_carry;
  logic             core_zero;

  case_example_alu #(.WIDTH(WIDTH)) u_alu (
    .sel   (sel),
    .a     (a),
    .b     (b),
    .r     (core_r),
    .carry (core_carry),
    .zero  (core_zero)
  );

  // Result and flags hold on idle cycles; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      y         <= core_r;
      carry     <= core_carry;
      zero      <= core_zero;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_case_example.sv
// Scoreboard bench for case_example: driver queues expectations, monitor compares.
module tb_case_example;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [3:0] y;
  logic       out_valid;
  logic       carry;
  logic       zero;

  typedef struct {
    logic       ov;
    logic [3:0] y;
    logic       c;
    logic       z;
    int         id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   vec_id = 0;

  case_example #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sel       (sel),
    .a         (a),
    .b         (b),
    .y         (y),
    .out_valid (out_valid),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int id, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want)
      $display("FAIL %s vec%0d: got %0d expected %0d", name, id, got, want);
    else
      passed++;
  endtask

  // Inputs change on the falling edge; the result is due after the next rising edge.
  task automatic step(input logic r, input logic iv, input logic [1:0] s,
                      input logic [3:0] aa, input logic [3:0] bb,
                      input logic eov, input logic [3:0] ey, input logic ec, input logic ez);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = iv; sel = s; a = aa; b = bb;
    e.ov = eov; e.y = ey; e.c = ec; e.z = ez; e.id = vec_id;
    q.push_back(e);
    vec_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("out_valid", e.id, {3'b0, out_valid}, {3'b0, e.ov});
        cmp("y",         e.id, y, e.y);
        cmp("carry",     e.id, {3'b0, carry}, {3'b0, e.c});
        cmp("zero",      e.id, {3'b0, zero},  {3'b0, e.z});
      end
    end
  end

  initial begin : driver
    exp_t e;
    int   wait_cycles;
    //    rst iv  sel    a      b      ov  y      c  z
    step(1, 0, 2'd0, 4'd0,  4'd0,  0, 4'd0,  0, 1);
    step(1, 1, 2'd0, 4'd7,  4'd3,  0, 4'd0,  0, 1);
    step(0, 0, 2'd0, 4'd7,  4'd3,  0, 4'd0,  0, 1);
    step(0, 1, 2'd0, 4'd7,  4'd3,  1, 4'd10, 0, 0);
    step(0, 1, 2'd1, 4'd7,  4'd3,  1, 4'd4,  0, 0);
    step(0, 1, 2'd2, 4'd7,  4'd3,  1, 4'd3,  0, 0);
    step(0, 1, 2'd3, 4'd7,  4'd3,  1, 4'd7,  0, 0);
    step(0, 1, 2'd0, 4'd15, 4'd1,  1, 4'd0,  1, 1);
    step(0, 0, 2'd2, 4'd6,  4'd6,  0, 4'd0,  1, 1);
    step(0, 1, 2'd1, 4'd3,  4'd7,  1, 4'd12, 1, 0);

    // Unknown opcode: a two-state simulator may resolve xx to a legal code.
    @(negedge clk);
    rst = 0; in_valid = 1; a = 4'd7; b = 4'd3; sel = 2'bxx;
    e.ov = 1; e.id = vec_id; vec_id++;
    if ($isunknown(sel)) begin e.y = 4'd0; e.c = 0; e.z = 1; end
    else begin
      case (sel)
        2'd0:    begin e.y = 4'd10; e.c = 0; e.z = 0; end
        2'd1:    begin e.y = 4'd4;  e.c = 0; e.z = 0; end
        2'd2:    begin e.y = 4'd3;  e.c = 0; e.z = 0; end
        default: begin e.y = 4'd7;  e.c = 0; e.z = 0; end
      endcase
    end
    q.push_back(e);

    step(0, 1, 2'd0, 4'd7,  4'd3,  1, 4'd10, 0, 0);
    step(0, 0, 2'd3, 4'd1,  4'd1,  0, 4'd10, 0, 0);
    step(0, 0, 2'd3, 4'd1,  4'd1,  0, 4'd10, 0, 0);
    step(0, 1, 2'd0, 4'd9,  4'd6,  1, 4'd15, 0, 0);
    step(0, 1, 2'd2, 4'd12, 4'd10, 1, 4'd8,  0, 0);
    step(0, 1, 2'd3, 4'd5,  4'd10, 1, 4'd15, 0, 0);
    step(0, 1, 2'd1, 4'd8,  4'd8,  1, 4'd0,  0, 1);
    step(0, 1, 2'd1, 4'd0,  4'd1,  1, 4'd15, 1, 0);
    step(0, 1, 2'd0, 4'd15, 4'd15, 1, 4'd14, 1, 0);
    step(0, 1, 2'd0, 4'd7,  4'd3,  1, 4'd10, 0, 0);
    step(1, 1, 2'd0, 4'd7,  4'd3,  0, 4'd0,  0, 1);
    step(0, 1, 2'd1, 4'd5,  4'd5,  1, 4'd0,  0, 1);
    step(0, 0, 2'd0, 4'd0,  4'd0,  0, 4'd0,  0, 1);

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/case_example.md
# case_example

Registered 4-bit, four-operation ALU selected by a 2-bit opcode: add, subtract, bitwise AND, bitwise OR. It is a small datapath leaf used wherever a one-of-four arithmetic/logic result is needed with a single-cycle registered output. Combinational core evaluation is followed by an output register with valid and status flags.

## Interface

Parameters:
- WIDTH, 4, operand/result width in bits (all examples below use 4).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operands/opcode valid this cycle.
- sel  input  2  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- y  output  WIDTH  registered result.
- out_valid  output  1  y/flags updated from a valid input last cycle.
- carry  output  1  ADD: carry-out; SUB: borrow (a < b); AND/OR: 0.
- zero  output  1  y == 0.

## Operation

- Core result r by sel:
  - 0: r = (a + b) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 1: r = (a − b) mod 2^WIDTH, two's-complement wrap; carry = 1 iff a < b unsigned.
  - 2: r = a & b; carry = 0.
  - 3: r = a | b; carry = 0.
  - Any non-0..3 sel value (X/Z in simulation): r = 0, carry = 0 (case default).
- zero computed from r, not from the registered y.
- No signed interpretation; no overflow flag.

## Timing

- All outputs registered; latency 1 cycle from in_valid sample to out_valid/y.
- On rising clk with rst=1: y=0, carry=0, zero=1, out_valid=0. rst has priority over in_valid.
- On rising clk with rst=0, in_valid=1: y←r, carry←core carry, zero←(r==0), out_valid←1.
- On rising clk with rst=0, in_valid=0: y, carry, zero hold their previous values; out_valid←0.
- Back-to-back in_valid every cycle supported; no backpressure.
- Reset asserted mid-stream discards the in-flight result; the first valid after reset release appears one cycle later.

## Structure

- Package case_example_pkg: opcode constants OP_ADD=2'd0, OP_SUB=2'd1, OP_AND=2'd2, OP_OR=2'd3; opcode typedef (2-bit enum).
- Sub-module case_example_alu: purely combinational core (a, b, sel → r, carry, zero) built on a single case statement with default branch. Top-level case_example instantiates it and adds the register stage.

## Test plan

- Reset: rst=1 for 2 cycles -> y=0, zero=1, carry=0, out_valid=0; release -> outputs unchanged until a valid input.
- a=7, b=3, in_valid=1, sel=0,1,2,3 on successive cycles -> y=10, 4, 3, 7 one cycle after each; carry=0 throughout; out_valid=1.
- Wrap: a=15, b=1, sel=0 -> y=0, carry=1, zero=1; a=3, b=7, sel=1 -> y=12, carry=1, zero=0.
- Unknown opcode: sel=2'bxx, a=7, b=3, in_valid=1 -> y=0, carry=0, zero=1.
- Hold: valid a=7, b=3, sel=0 (y=10), then in_valid=0 with a=1, b=1, sel=3 -> y stays 10, out_valid=0.
- Reset mid-stream: in_valid=1 with a=7, b=3, sel=0, and rst=1 in the same cycle -> y=0, out_valid=0; a valid a=5, b=5, sel=1 after release -> y=0, zero=1.
